mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 148 ++++++++++++++
 tb/tb_mult_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Command sequencer for an external add-shift 8x8 signed multiplier. It loads B, runs
// Execute with A, waits for the run to finish, then captures {Aval,Bval} and X.
module mult_sequencer #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned RUN_CYCLES  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  op_a_i,
    input  logic [7:0]  op_b_i,
    output logic [7:0]  din_o,
    output logic        clear_a_load_b_n_o,
    output logic        execute_n_o,
    input  logic [7:0]  aval_i,
    input  logic [7:0]  bval_i,
    input  logic        x_i,
    output logic [15:0] result_o,
    output logic        result_x_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > RUN_CYCLES) ? HOLD_CYCLES : RUN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADB,
        S_GAP1,
        S_EXEC,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic [7:0]       op_a_q;
    logic [7:0]       op_b_q;
    logic [7:0]       din_q;
    logic             clr_n_q;
    logic             exe_n_q;
    logic [15:0]      result_q;
    logic             result_x_q;
    logic             busy_q;
    logic             done_q;

    logic start_edge_d;
    logic cnt_zero_d;

    assign start_edge_d = start_i & ~start_q;
    assign cnt_zero_d   = (cnt_q == '0);

    // Every output is set one cycle ahead, on the edge that enters the state it belongs
    // to, so the command strobes come straight from flops and line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            start_q    <= 1'b1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            din_q      <= '0;
            clr_n_q    <= 1'b1;
            exe_n_q    <= 1'b1;
            result_q   <= '0;
            result_x_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= start_i;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_edge_d) begin
                        op_a_q  <= op_a_i;
                        op_b_q  <= op_b_i;
                        din_q   <= op_b_i;
                        clr_n_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= HOLD_LOAD;
                        state_q <= S_LOADB;
                    end
                end
                S_LOADB: begin
                    if (cnt_zero_d) begin
                        clr_n_q <= 1'b1;
                        din_q   <= op_a_q;
                        state_q <= S_GAP1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_GAP1: begin
                    exe_n_q <= 1'b0;
                    cnt_q   <= HOLD_LOAD;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_zero_d) begin
                        exe_n_q <= 1'b1;
                        cnt_q   <= RUN_LOAD;
                        state_q <= S_RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (cnt_zero_d) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    result_q   <= {aval_i, bval_i};
                    result_x_q <= x_i;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    clr_n_q <= 1'b1;
                    exe_n_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign din_o              = din_q;
    assign clear_a_load_b_n_o = clr_n_q;
    assign execute_n_o        = exe_n_q;
    assign result_o           = result_q;
    assign result_x_o         = result_x_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: two instances (default timing and 1/1 timing) each driving a
// behavioral multiplier; a done-triggered monitor checks results against a queue.
module tb_mult_sequencer;

    typedef struct {
        logic [15:0] res;
        logic        x;
        int          lat;
        int          t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    // dut0: default timing
    logic        start0 = 1'b1;
    logic [7:0]  opa0 = 8'h00, opb0 = 8'h00;
    logic [7:0]  din0;
    logic        clr0_n, exe0_n;
    logic [15:0] res0;
    logic        resx0, busy0, done0;
    logic [15:0] m0_p = 16'h0000;
    logic        m0_x = 1'b0;
    logic [7:0]  m0_a = 8'h00, m0_b = 8'h00;
    logic        m0_prev = 1'b1;
    logic        m0_pend = 1'b0;
    int          m0_cnt = 0;
    logic signed [15:0] prod0;

    // dut1: HOLD_CYCLES=1, RUN_CYCLES=1
    logic        start1 = 1'b0;
    logic [7:0]  opa1 = 8'h00, opb1 = 8'h00;
    logic [7:0]  din1;
    logic        clr1_n, exe1_n;
    logic [15:0] res1;
    logic        resx1, busy1, done1;
    logic [15:0] m1_p = 16'h0000;
    logic        m1_x = 1'b0;
    logic [7:0]  m1_a = 8'h00, m1_b = 8'h00;
    logic        m1_prev = 1'b1;
    logic signed [15:0] prod1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .op_a_i(opa0), .op_b_i(opb0),
        .din_o(din0), .clear_a_load_b_n_o(clr0_n), .execute_n_o(exe0_n),
        .aval_i(m0_p[15:8]), .bval_i(m0_p[7:0]), .x_i(m0_x),
        .result_o(res0), .result_x_o(resx0), .busy_o(busy0), .done_o(done0)
    );

    mult_sequencer #(.HOLD_CYCLES(1), .RUN_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .op_a_i(opa1), .op_b_i(opb1),
        .din_o(din1), .clear_a_load_b_n_o(clr1_n), .execute_n_o(exe1_n),
        .aval_i(m1_p[15:8]), .bval_i(m1_p[7:0]), .x_i(m1_x),
        .result_o(res1), .result_x_o(resx1), .busy_o(busy1), .done_o(done1)
    );

    // Behavioral multiplier, 18-cycle latency after Execute rises
    assign prod0 = $signed(m0_a) * $signed(m0_b);
    always @(posedge clk) begin
        m0_prev <= exe0_n;
        if (!clr0_n) begin
            m0_b <= din0;
            m0_p <= {8'h00, din0};
            m0_x <= 1'b0;
        end
        if (!exe0_n) m0_a <= din0;
        if (exe0_n && !m0_prev) begin
            m0_pend <= 1'b1;
            m0_cnt  <= 18;
        end else if (m0_pend) begin
            if (m0_cnt <= 1) begin
                m0_p    <= prod0;
                m0_x    <= prod0[15];
                m0_pend <= 1'b0;
            end else begin
                m0_cnt <= m0_cnt - 1;
            end
        end
    end

    // Behavioral multiplier, zero latency after Execute rises
    assign prod1 = $signed(m1_a) * $signed(m1_b);
    always @(posedge clk) begin
        m1_prev <= exe1_n;
        if (!clr1_n) begin
            m1_b <= din1;
            m1_p <= {8'h00, din1};
            m1_x <= 1'b0;
        end
        if (!exe1_n) m1_a <= din1;
        if (exe1_n && !m1_prev) begin
            m1_p <= prod1;
            m1_x <= prod1[15];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives a start edge on dut0 at the next negedge; optionally queues the expected result
    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic push,
                          input logic [15:0] res, input logic x);
        exp_t e;
        @(negedge clk);
        opa0   = a;
        opb0   = b;
        start0 = 1'b1;
        if (push) begin
            e.res = res; e.x = x; e.lat = 31; e.t0 = cyc;
            q0.push_back(e);
        end
    endtask

    task automatic wait_done0();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done0 && k < 200);
        if (!done0) chk("done0_timeout", 32'd0, 32'd1);
    endtask

    // Monitors: one line per completed transaction
    always @(negedge clk) begin
        if (rst_n && !(clr0_n && exe0_n)) chk("dut0_cmd_overlap", {31'd0, clr0_n | exe0_n}, 32'd1);
        if (rst_n && !(clr1_n && exe1_n)) chk("dut1_cmd_overlap", {31'd0, clr1_n | exe1_n}, 32'd1);
        if (done0) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_done", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                $display("txn dut0 result=%h x=%b latency=%0d", res0, resx0, cyc - e0.t0);
                chk("dut0_result", {16'd0, res0}, {16'd0, e0.res});
                chk("dut0_result_x", {31'd0, resx0}, {31'd0, e0.x});
                chk("dut0_latency", cyc - e0.t0, e0.lat);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                $display("txn dut1 result=%h x=%b latency=%0d", res1, resx1, cyc - e1.t0);
                chk("dut1_result", {16'd0, res1}, {16'd0, e1.res});
                chk("dut1_result_x", {31'd0, resx1}, {31'd0, e1.x});
                chk("dut1_latency", cyc - e1.t0, e1.lat);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset state, with Start already high
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_clr_n", {31'd0, clr0_n}, 32'd1);
        chk("rst_exe_n", {31'd0, exe0_n}, 32'd1);
        chk("rst_din", {24'd0, din0}, 32'd0);
        chk("rst_result", {16'd0, res0}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("start_high_at_release", {31'd0, busy0}, 32'd0);
        start0 = 1'b0;

        // Basic operation with command waveform
        issue0(8'h07, 8'hC5, 1'b1, 16'hFE63, 1'b1);
        chk("edge_cycle_busy", {31'd0, busy0}, 32'd0);
        for (int m = 1; m <= 6; m++) begin
            @(negedge clk);
            if (m == 1) start0 = 1'b0;
            chk("wave_busy", {31'd0, busy0}, 32'd1);
            chk("wave_clr_n", {31'd0, clr0_n}, (m == 1 || m == 2) ? 32'd0 : 32'd1);
            chk("wave_exe_n", {31'd0, exe0_n}, (m == 4 || m == 5) ? 32'd0 : 32'd1);
            chk("wave_din", {24'd0, din0}, (m <= 2) ? 32'hC5 : 32'h07);
        end
        wait_done0();

        // Sign corner cases, each started in the first IDLE cycle after DONE
        issue0(8'h01, 8'hFF, 1'b1, 16'hFFFF, 1'b1);
        @(negedge clk); start0 = 1'b0;
        wait_done0();
        issue0(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
        @(negedge clk); start0 = 1'b0;
        wait_done0();
        chk("result_holds", {16'd0, res0}, 32'h0001);
        issue0(8'hCA, 8'hFE, 1'b1, 16'h006C, 1'b0);
        @(negedge clk); start0 = 1'b0;
        wait_done0();

        // Start held high plus an extra pulse while busy: one operation only
        issue0(8'h03, 8'h04, 1'b1, 16'h000C, 1'b0);
        repeat (10) @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        wait_done0();
        repeat (5) @(negedge clk);
        chk("held_start_no_relaunch", {31'd0, busy0}, 32'd0);
        start0 = 1'b0;
        @(negedge clk);

        // Reset during RUN aborts at once without Done
        issue0(8'h11, 8'h22, 1'b0, 16'h0000, 1'b0);
        @(negedge clk); start0 = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_clr_n", {31'd0, clr0_n}, 32'd1);
        chk("abort_exe_n", {31'd0, exe0_n}, 32'd1);
        chk("abort_result", {16'd0, res0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_din", {24'd0, din0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue0(8'h02, 8'h03, 1'b1, 16'h0006, 1'b0);
        @(negedge clk); start0 = 1'b0;
        wait_done0();

        // Start edge in DONE is ignored; edge in the next cycle is accepted
        issue0(8'h04, 8'h05, 1'b1, 16'h0014, 1'b0);
        @(negedge clk); start0 = 1'b0;
        wait_done0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_cycle_edge_ignored", {31'd0, busy0}, 32'd0);
        end
        issue0(8'h06, 8'h07, 1'b1, 16'h002A, 1'b0);
        @(negedge clk); start0 = 1'b0;
        wait_done0();
        issue0(8'hF0, 8'h03, 1'b1, 16'hFFD0, 1'b1);
        @(negedge clk);
        chk("next_cycle_edge_busy", {31'd0, busy0}, 32'd1);
        start0 = 1'b0;
        wait_done0();

        // Minimum timing instance
        @(negedge clk);
        opa1 = 8'h05; opb1 = 8'hFD; start1 = 1'b1;
        e.res = 16'hFFF1; e.x = 1'b1; e.lat = 6; e.t0 = cyc;
        q1.push_back(e);
        for (int m = 1; m <= 5; m++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("min_clr_n", {31'd0, clr1_n}, (m == 1) ? 32'd0 : 32'd1);
            chk("min_exe_n", {31'd0, exe1_n}, (m == 3) ? 32'd0 : 32'd1);
            chk("min_din", {24'd0, din1}, (m == 1) ? 32'hFD : 32'h05);
        end
        repeat (4) @(negedge clk);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
